wishbone_board_mem: RTL and testbench
=====================================

# wishbone_board_mem

Pipelined Wishbone slave holding the Minesweeper board cell array, one byte per cell. It sits directly downstream of the two-master Wishbone arbiter and consumes its slave-side bus (adr/dat/we/stb/cyc in; dat/ack/stall out). It adds a hardware clear sweep that initialises every cell after reset or on request from game control, stalling the bus while the sweep runs.

## Interface
Parameters:
- ADDR_WIDTH, 8, cell address width; depth = 2**ADDR_WIDTH (256 = 16x16 board).
- DATA_WIDTH, 8, cell word width.
- INIT_VALUE, 0, value written to every cell by the clear sweep.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wb_cyc_i  input  1  bus cycle, from arbiter cyc_o.
- wb_stb_i  input  1  strobe, from arbiter stb_o.
- wb_we_i  input  1  1 = write, 0 = read.
- wb_adr_i  input  ADDR_WIDTH  cell address.
- wb_dat_i  input  DATA_WIDTH  write data.
- wb_dat_o  output  DATA_WIDTH  read data, to arbiter dat_i.
- wb_ack_o  output  1  transfer acknowledge, to arbiter ack_i.
- wb_stall_o  output  1  stall, to arbiter stall_i.
- clear_i  input  1  single-cycle pulse: request full-board clear.
- busy_o  output  1  high while clear sweep in progress.

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH synchronous single-port RAM. Every address is valid; there are no bus errors.
- FSM states:
  - CLEAR: sweep counter 0..2**ADDR_WIDTH-1, one write of INIT_VALUE per cycle. wb_stall_o=1, busy_o=1, no bus requests accepted. After writing the last address -> READY.
  - READY: wb_stall_o=0, busy_o=0.
- Accept condition: READY & wb_cyc_i & wb_stb_i & !wb_stall_o.
- Accepted write: RAM[wb_adr_i] <= wb_dat_i at that edge; wb_dat_o unchanged.
- Accepted read: wb_dat_o <= RAM[wb_adr_i] (registered).
- Either type sets an internal ack flag. wb_ack_o = ack flag & wb_cyc_i, so an ack is dropped if the master abandons the cycle. A write committed before the drop stays committed.
- clear_i in READY: READY -> CLEAR at the next edge. A request accepted in the same cycle as clear_i completes normally, with its ack in the first CLEAR cycle. clear_i in CLEAR is ignored; the sweep is not restarted.
- Reset: async assert forces CLEAR, counter=0, ack flag=0, wb_dat_o=0. Reset mid-sweep or mid-transfer restarts the sweep from address 0 after release; an in-flight ack is lost.
- Counter width is ADDR_WIDTH+1 or an explicit last-address compare. It must not wrap and re-sweep.

## Timing
- Reset values: wb_ack_o=0, wb_dat_o=0, wb_stall_o=1, busy_o=1.
- Clear duration: exactly 2**ADDR_WIDTH cycles of busy_o=1 after reset release or after a clear_i edge (256 for defaults). wb_stall_o falls in the same cycle as busy_o.
- Latency: request accepted at edge N -> wb_ack_o high in cycle N..N+1, with read data valid on wb_dat_o in the same cycle.
- Throughput: one transfer per cycle, back-to-back, no bubbles.
- Read-after-write to the same address on consecutive cycles returns the new data.
- wb_dat_o holds the last read value until the next accepted read.

## Test plan
- Reset release -> busy_o and wb_stall_o high for exactly 256 cycles, then low. A read of every address returns 0x00, each acked one cycle after acceptance.
- Write 0xA5 to address 0x3C, then read 0x3C on the next cycle -> ack on both; read returns 0xA5 one cycle after acceptance.
- Pipelined burst: reads at 0x00..0x07 on 8 consecutive cycles, after prior writes of 0x10..0x17 -> 8 consecutive acks carrying 0x10..0x17 in order, stall never asserted.
- clear_i pulsed in the same cycle as an accepted write of 0x55 to 0x01 -> write acked in the next cycle. busy_o stays high for 256 cycles; afterwards address 0x01 reads 0x00.
- Master drops wb_cyc_i in the cycle after an accepted read -> wb_ack_o stays 0. A following write of 0x77 to 0x02 is acked normally.
- rst_n asserted mid-sweep at counter 100 -> outputs return to reset values immediately. After release, busy_o stays high for a full 256 cycles.

Source files
------------

// File: rtl/wishbone_board_mem_if.sv
// Wishbone pipelined bus bundle between the arbiter (master side) and the
// board cell memory (slave side).
//   cyc, stb, we, adr, dat_w : master -> slave request signals
//   dat_r, ack, stall        : slave -> master response signals
interface wishbone_board_mem_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat_w;
    logic [DATA_WIDTH-1:0] dat_r;
    logic                  ack;
    logic                  stall;

    modport master (
        output cyc, stb, we, adr, dat_w,
        input  dat_r, ack, stall
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w,
        output dat_r, ack, stall
    );
endinterface

// File: rtl/wishbone_board_mem.sv
// Minesweeper board cell memory: pipelined Wishbone slave, one byte per cell,
// with a hardware clear sweep that writes INIT_VALUE to every cell after reset
// or on a clear_i pulse. The bus is stalled while the sweep runs.
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   wb       Wishbone slave modport (cyc/stb/we/adr/dat_w in, dat_r/ack/stall out)
//   clear_i  single-cycle request for a full-board clear (ignored while clearing)
//   busy_o   high while the clear sweep is in progress
module wishbone_board_mem #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    wishbone_board_mem_if.slave      wb,
    input  logic                     clear_i,
    output logic                     busy_o
);
    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        dat_d     = dat_q;
        mem_we    = 1'b0;
        mem_addr  = wb.adr;
        mem_wdata = wb.dat_w;
        case (state_q)
            ST_CLEAR: begin
                // Sweep owns the RAM port; the explicit last-address compare
                // ends the sweep without the counter wrapping into a second pass.
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = INIT_VALUE;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                // Stall is low here, so any strobe inside a cycle is accepted.
                if (wb.cyc && wb.stb) begin
                    ack_d = 1'b1;
                    if (wb.we) begin
                        mem_we = 1'b1;
                    end else begin
                        dat_d = mem[wb.adr];
                    end
                end
                // A request accepted alongside clear_i still completes; its
                // ack appears in the first sweep cycle.
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    // Storage has no reset; the sweep gives it defined contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Ack is masked by cyc so an abandoned cycle never sees a stale ack.
    assign wb.ack   = ack_q & wb.cyc;
    assign wb.dat_r = dat_q;
    assign wb.stall = (state_q == ST_CLEAR);
    assign busy_o   = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_wishbone_board_mem.sv
module tb_wishbone_board_mem;
    logic clk;
    logic rst_n;
    logic clear_i;
    logic busy_o;
    int   n_cmp;
    int   n_err;
    int   busy_len;
    bit   stall_ok;

    wishbone_board_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    wishbone_board_mem #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .INIT_VALUE(8'h00)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wb     (bus),
        .clear_i(clear_i),
        .busy_o (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.stb   = 1'b0;
        bus.we    = 1'b0;
        bus.adr   = '0;
        bus.dat_w = '0;
    endtask

    task automatic drive(input logic we, input logic [7:0] adr, input logic [7:0] dat);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = we;
        bus.adr   = adr;
        bus.dat_w = dat;
    endtask

    // Counts consecutive cycles with busy_o high starting at the current
    // sample, optionally pulsing clear_i partway through.
    task automatic count_busy(input int pulse_at, output int n, output bit s_ok);
        n    = 0;
        s_ok = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (bus.stall !== busy_o) s_ok = 1'b0;
            if (busy_o !== 1'b1) break;
            n++;
            if (n == pulse_at) clear_i = 1'b1;
            step();
            clear_i = 1'b0;
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        clear_i = 1'b0;
        bus.cyc = 1'b0;
        idle();

        // Reset state
        repeat (3) step();
        chk("rst_ack", {31'd0, bus.ack}, 32'd0);
        chk("rst_dat", {24'd0, bus.dat_r}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd1);

        // Sweep after reset release
        rst_n = 1'b1;
        count_busy(0, busy_len, stall_ok);
        chk("init_busy_len", busy_len, 32'd256);
        chk("init_stall_eq", {31'd0, stall_ok}, 32'd1);

        // Read every address, pipelined
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 8'(i), 8'h00);
            step();
            chk($sformatf("rd_all_ack_%0d", i), {31'd0, bus.ack}, 32'd1);
            chk($sformatf("rd_all_dat_%0d", i), {24'd0, bus.dat_r}, 32'h00);
        end
        idle();
        step();

        // Write then read-after-write
        drive(1'b1, 8'h3C, 8'hA5);
        step();
        chk("raw_wr_ack", {31'd0, bus.ack}, 32'd1);
        chk("raw_wr_dat_hold", {24'd0, bus.dat_r}, 32'h00);
        drive(1'b0, 8'h3C, 8'h00);
        step();
        chk("raw_rd_ack", {31'd0, bus.ack}, 32'd1);
        chk("raw_rd_dat", {24'd0, bus.dat_r}, 32'hA5);
        idle();
        step();
        chk("idle_ack", {31'd0, bus.ack}, 32'd0);

        // Pipelined writes then burst reads
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), 8'(8'h10 + i));
            step();
            chk($sformatf("bw_ack_%0d", i), {31'd0, bus.ack}, 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'(i), 8'h00);
            chk($sformatf("br_stall_%0d", i), {31'd0, bus.stall}, 32'd0);
            step();
            chk($sformatf("br_ack_%0d", i), {31'd0, bus.ack}, 32'd1);
            chk($sformatf("br_dat_%0d", i), {24'd0, bus.dat_r}, 32'(8'h10 + i));
        end
        idle();
        step();

        // Clear requested alongside an accepted write; second clear mid-sweep ignored
        drive(1'b1, 8'h01, 8'h55);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        idle();
        chk("clr_wr_ack", {31'd0, bus.ack}, 32'd1);
        chk("clr_busy", {31'd0, busy_o}, 32'd1);
        count_busy(50, busy_len, stall_ok);
        chk("clr_busy_len", busy_len, 32'd256);
        chk("clr_stall_eq", {31'd0, stall_ok}, 32'd1);
        drive(1'b0, 8'h01, 8'h00);
        step();
        chk("clr_rd01_ack", {31'd0, bus.ack}, 32'd1);
        chk("clr_rd01_dat", {24'd0, bus.dat_r}, 32'h00);
        drive(1'b0, 8'h3C, 8'h00);
        step();
        chk("clr_rd3c_dat", {24'd0, bus.dat_r}, 32'h00);
        idle();
        step();

        // Master abandons cycle after an accepted read
        drive(1'b0, 8'h07, 8'h00);
        step();
        bus.cyc = 1'b0;
        idle();
        #1;
        chk("drop_ack", {31'd0, bus.ack}, 32'd0);
        step();
        drive(1'b1, 8'h02, 8'h77);
        step();
        chk("drop_wr_ack", {31'd0, bus.ack}, 32'd1);
        drive(1'b0, 8'h02, 8'h00);
        step();
        chk("drop_rd_dat", {24'd0, bus.dat_r}, 32'h77);
        drive(1'b1, 8'h03, 8'h12);
        step();
        chk("hold_wr_ack", {31'd0, bus.ack}, 32'd1);
        chk("hold_dat", {24'd0, bus.dat_r}, 32'h77);
        idle();
        step();

        // Reset asserted mid-sweep at counter 100
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        repeat (100) step();
        chk("mid_busy", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", {31'd0, bus.ack}, 32'd0);
        chk("mid_rst_dat", {24'd0, bus.dat_r}, 32'h00);
        chk("mid_rst_stall", {31'd0, bus.stall}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd1);
        repeat (2) step();
        rst_n = 1'b1;
        count_busy(0, busy_len, stall_ok);
        chk("mid_busy_len", busy_len, 32'd256);
        chk("mid_stall_eq", {31'd0, stall_ok}, 32'd1);
        drive(1'b0, 8'h02, 8'h00);
        step();
        chk("mid_rd02_ack", {31'd0, bus.ack}, 32'd1);
        chk("mid_rd02_dat", {24'd0, bus.dat_r}, 32'h00);
        idle();
        bus.cyc = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
